// File: rtl/axis_arbiter_if.sv
// axis_arbiter_if: NS incoming AXI-Stream ports plus one merged output stream
interface axis_arbiter_if #(
    parameter int C_AXIS_DATA_WIDTH = 16,
    parameter int NS                = 4
);
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    logic [NS-1:0]                   S_AXIS_TVALID;
    logic [NS-1:0]                   S_AXIS_TREADY;
    logic [NS*C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA;
    logic [NS-1:0]                   S_AXIS_TLAST;
    logic                            M_AXIS_TVALID;
    logic                            M_AXIS_TREADY;
    logic [C_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA;
    logic                            M_AXIS_TLAST;
    logic [IW-1:0]                   M_AXIS_TID;
    modport master (
        input  S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TLAST, M_AXIS_TREADY,
        output S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TID
    );
    modport slave (
        output S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TLAST, M_AXIS_TREADY,
        input  S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TID
    );
endinterface

// File: rtl/axis_arbiter.sv
// axis_arbiter: round-robin merge of NS AXI-Stream ports into one registered output stream
module axis_arbiter #(
    parameter int C_AXIS_DATA_WIDTH = 16,
    parameter int NS                = 4,
    parameter int OPT_LOCK          = 1
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESETN,
    axis_arbiter_if.master      bus
);
    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        r_state;
    logic [IW-1:0] r_grant;
    logic [IW-1:0] r_last;
    logic [IW-1:0] r_tid;
    logic          r_mvalid;
    logic          r_mlast;
    logic [DW-1:0] r_mdata;
    logic [DW-1:0] w_lane [NS];
    logic [NS-1:0] w_rot;
    logic [IW-1:0] w_next;
    logic          w_found;
    logic          w_take;
    logic          w_accept;
    logic          w_release;

    for (genvar k = 0; k < NS; k++) begin : g_lane
        assign w_lane[k] = bus.S_AXIS_TDATA[k*DW +: DW];
    end

    // Valid bits rotated so bit 0 is the port just after the last one served
    assign w_rot = NS'({bus.S_AXIS_TVALID, bus.S_AXIS_TVALID} >> (int'(r_last) + 1));

    always_comb begin
        w_found = 1'b0;
        w_next  = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_next  = IW'((int'(r_last) + 1 + i) % NS);
            end
        end
    end

    assign w_take    = !r_mvalid || bus.M_AXIS_TREADY;
    assign w_accept  = (r_state == LOCKED) && bus.S_AXIS_TVALID[r_grant] && w_take;
    assign w_release = w_accept && (OPT_LOCK == 0 || bus.S_AXIS_TLAST[r_grant]);

    assign bus.S_AXIS_TREADY = (r_state == LOCKED && w_take) ? NS'(1) << r_grant : '0;
    assign bus.M_AXIS_TVALID = r_mvalid;
    assign bus.M_AXIS_TDATA  = r_mdata;
    assign bus.M_AXIS_TLAST  = r_mlast;
    assign bus.M_AXIS_TID    = r_tid;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_last   <= IW'(NS - 1);
            r_mvalid <= 1'b0;
            r_mdata  <= '0;
            r_mlast  <= 1'b0;
            r_tid    <= '0;
        end else begin
            if (w_accept) begin
                r_mvalid <= 1'b1;
                r_mdata  <= w_lane[r_grant];
                r_mlast  <= bus.S_AXIS_TLAST[r_grant];
                r_tid    <= r_grant;
            end else if (bus.M_AXIS_TREADY) begin
                r_mvalid <= 1'b0;
            end
            if (r_state == IDLE && w_found) begin
                r_state <= LOCKED;
                r_grant <= w_next;
            end else if (w_release) begin
                r_state <= IDLE;
                r_last  <= r_grant;
            end
        end
    end
endmodule

// File: doc/axis_arbiter.md
AXIS_ARBITER -- requirements
Module: axis_arbiter

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 16, width of each TDATA lane (DW).
REQ-002 SHALL have parameter NS, default 4, number of slave (incoming) stream ports, NS>=1.
REQ-003 SHALL have parameter OPT_LOCK, default 1: 1 = grant held until a beat with TLAST is accepted; 0 = grant released after every accepted beat.
REQ-004 SHALL define IW = max(1, clog2(NS)) for index-width rules.
REQ-005 SHALL have port S_AXI_ACLK  input  1  sole clock; all state on its rising edge.
REQ-006 SHALL have port S_AXI_ARESETN  input  1  reset, asynchronous assertion, active-low.
REQ-007 SHALL have port S_AXIS_TVALID  input  NS  per-port beat valid.
REQ-008 SHALL have port S_AXIS_TREADY  output  NS  per-port beat ready.
REQ-009 SHALL have port S_AXIS_TDATA  input  NS*DW  port k occupies bits [k*DW +: DW].
REQ-010 SHALL have port S_AXIS_TLAST  input  NS  per-port end of packet.
REQ-011 SHALL have port M_AXIS_TVALID  output  1  merged stream valid (registered).
REQ-012 SHALL have port M_AXIS_TREADY  input  1  merged stream ready.
REQ-013 SHALL have port M_AXIS_TDATA  output  DW  merged data (registered).
REQ-014 SHALL have port M_AXIS_TLAST  output  1  merged TLAST (registered).
REQ-015 SHALL have port M_AXIS_TID  output  IW  index of source port of current output beat (registered).

Function
REQ-016 SHALL implement two states: IDLE (no grant) and LOCKED (grant index g held).
REQ-017 In IDLE, all S_AXIS_TREADY SHALL be 0.
REQ-018 In IDLE with any S_AXIS_TVALID set, SHALL select the first valid port searching (last+1), (last+2), ... mod NS, register it as g, and enter LOCKED next cycle; with none valid, remain IDLE.
REQ-019 In LOCKED, S_AXIS_TREADY[g] SHALL equal (!M_AXIS_TVALID || M_AXIS_TREADY); all other TREADY bits 0.
REQ-020 On accepted beat (S_AXIS_TVALID[g] && S_AXIS_TREADY[g]), SHALL load M_AXIS_TDATA/TLAST from port g, M_AXIS_TID<=g, M_AXIS_TVALID<=1; latency input acceptance to output valid = 1 cycle.
REQ-021 M_AXIS_TVALID SHALL clear after M_AXIS_TVALID && M_AXIS_TREADY when no new beat loads that cycle; simultaneous drain and load SHALL keep TVALID=1 with new data (full throughput, no bubble within a packet).
REQ-022 While M_AXIS_TVALID && !M_AXIS_TREADY, M_AXIS_TDATA, TLAST, TID SHALL remain stable.
REQ-023 With OPT_LOCK=1, accepting a beat with TLAST=1 SHALL return to IDLE and set last<=g; other beats keep LOCKED.
REQ-024 With OPT_LOCK=0, every accepted beat SHALL return to IDLE and set last<=g.
REQ-025 Source deasserting TVALID mid-packet SHALL NOT release the grant (LOCKED held indefinitely).
REQ-026 One IDLE arbitration cycle SHALL separate consecutive grants (max 1 beat per 2 cycles under OPT_LOCK=0).
REQ-027 With NS=1, SHALL always grant port 0 and drive M_AXIS_TID=0.
REQ-028 Index arithmetic SHALL wrap modulo NS for non-power-of-two NS (no grant of index >= NS).

Reset
REQ-029 While S_AXI_ARESETN=0: state=IDLE, last=NS-1 (port 0 first priority), M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, M_AXIS_TID=0, all S_AXIS_TREADY=0.
REQ-030 Reset mid-packet SHALL discard the held beat and grant; sources SHALL see no further TREADY until re-arbitration after reset release.

Verification
REQ-031 Reset then TVALID on port 2 only, 3-beat packet 0x11,0x22,0x33(TLAST), M_AXIS_TREADY=1 -> output beats 0x11,0x22,0x33 consecutive, TID=2, TLAST only on third.
REQ-032 All 4 ports continuously valid with 1-beat packets (TLAST=1) -> grant order 0,1,2,3,0,1.
REQ-033 Port 1 mid-packet, port 0 valid, M_AXIS_TREADY held 0 for 5 cycles -> output data/TLAST/TID stable, TREADY[0]=0 throughout, port 1 completes before port 0 granted.
REQ-034 Port 3 drops TVALID for 4 cycles mid-packet while port 0 valid -> port 3 retains grant, no port 0 beat until port 3 TLAST accepted.
REQ-035 OPT_LOCK=0, ports 0 and 1 valid, TLAST=0 -> beats alternate TID 0,1,0,1.
REQ-036 Assert S_AXI_ARESETN=0 asynchronously mid-packet with M_AXIS_TVALID=1 -> M_AXIS_TVALID=0 immediately; after release first grant goes to lowest-index valid port.
